instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 156 +++++++++++++++
 tb/tb_instr_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction fetch/decode sequencer: fetches an opcode (optionally CB-prefixed)
// and up to two immediate bytes, then runs a microcode-timed EXEC phase.
module instr_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ready,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  opcode,
  output logic        cb_prefix,
  input  logic [59:0] control_signals,
  output logic [15:0] imm,
  output logic        exec_active,
  output logic [3:0]  exec_step,
  output logic        instr_done,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  input  logic        halt,
  output logic [15:0] pc
);

  typedef enum logic [2:0] {
    FETCH,
    PREFIX,
    IMM_LO,
    IMM_HI,
    EXEC
  } state_t;

  state_t      state_q, state_d, cur_state;
  logic        decode_pend_q, decode_pend_d;
  logic        run_q;
  logic [1:0]  imm_bytes;
  logic [3:0]  exec_last;
  logic        accept;
  logic [15:0] pc_d, imm_d;
  logic [7:0]  opcode_d;
  logic        cb_d;
  logic [3:0]  step_d;
  logic        unused_ctrl;

  assign unused_ctrl = ^control_signals[59:6];

  // Decode from the ROM word of the latched opcode.
  always_comb begin
    imm_bytes = (control_signals[1:0] == 2'd3) ? 2'd2 : control_signals[1:0];
    exec_last = (control_signals[5:2] == 4'd0) ? 4'd0 : control_signals[5:2] - 4'd1;
  end

  // After a plain opcode latches, the IMM_LO/EXEC choice is resolved in the
  // following cycle straight from the ROM output, so no decode cycle is spent.
  always_comb begin
    cur_state = state_q;
    if (decode_pend_q) begin
      cur_state = (imm_bytes != 2'd0) ? IMM_LO : EXEC;
    end
  end

  always_comb begin
    mem_addr    = pc;
    mem_rd      = run_q && (cur_state != EXEC) && !((cur_state == FETCH) && halt);
    accept      = mem_rd && mem_ready;
    exec_active = (cur_state == EXEC);
    instr_done  = exec_active && (exec_step == exec_last);
  end

  always_comb begin
    state_d       = cur_state;
    decode_pend_d = 1'b0;
    pc_d          = pc;
    opcode_d      = opcode;
    cb_d          = cb_prefix;
    imm_d         = imm;
    step_d        = exec_step;
    case (cur_state)
      FETCH: begin
        if (accept) begin
          pc_d = pc + 16'd1;
          if (mem_rdata == 8'hCB) begin
            cb_d    = 1'b1;
            state_d = PREFIX;
          end else begin
            opcode_d      = mem_rdata;
            cb_d          = 1'b0;
            imm_d         = '0;
            state_d       = IMM_LO;
            decode_pend_d = 1'b1;
          end
        end
      end
      PREFIX: begin
        if (accept) begin
          pc_d     = pc + 16'd1;
          opcode_d = mem_rdata;
          imm_d    = '0;
          state_d  = EXEC;
        end
      end
      IMM_LO: begin
        if (accept) begin
          pc_d       = pc + 16'd1;
          imm_d[7:0] = mem_rdata;
          state_d    = (imm_bytes == 2'd2) ? IMM_HI : EXEC;
        end
      end
      IMM_HI: begin
        if (accept) begin
          pc_d        = pc + 16'd1;
          imm_d[15:8] = mem_rdata;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        if (instr_done) begin
          step_d  = '0;
          state_d = FETCH;
          if (pc_load) begin
            pc_d = pc_load_value;
          end
        end else begin
          step_d = exec_step + 4'd1;
        end
      end
      default: begin
        state_d = FETCH;
        step_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= FETCH;
      decode_pend_q <= 1'b0;
      run_q         <= 1'b0;
      pc            <= RESET_PC;
      opcode        <= '0;
      cb_prefix     <= 1'b0;
      imm           <= '0;
      exec_step     <= '0;
    end else begin
      state_q       <= state_d;
      decode_pend_q <= decode_pend_d;
      run_q         <= 1'b1;
      pc            <= pc_d;
      opcode        <= opcode_d;
      cb_prefix     <= cb_d;
      imm           <= imm_d;
      exec_step     <= step_d;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized scoreboard bench for instr_sequencer: byte-stream memory model,
// random ROM, random stalls/halts/jumps, and an asynchronous mid-instruction reset.
`timescale 1ns/1ps
module tb_instr_sequencer;
  localparam logic [15:0] RPC = 16'hFFFF;

  logic        clk, reset_n;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_ready;
  logic [7:0]  mem_rdata, opcode;
  logic        cb_prefix;
  logic [59:0] control_signals;
  logic [15:0] imm, pc, pc_load_value;
  logic        exec_active, instr_done, pc_load, halt;
  logic [3:0]  exec_step;

  instr_sequencer #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset_n(reset_n), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .opcode(opcode),
    .cb_prefix(cb_prefix), .control_signals(control_signals), .imm(imm),
    .exec_active(exec_active), .exec_step(exec_step), .instr_done(instr_done),
    .pc_load(pc_load), .pc_load_value(pc_load_value), .halt(halt), .pc(pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  data;
    logic [15:0] addr;
  } byte_t;

  typedef struct packed {
    logic [7:0]  op;
    logic        cb;
    logic [15:0] imm;
    logic [15:0] pc_done;
    logic [4:0]  n;
    logic        jmp;
    logic [15:0] tgt;
  } rec_t;

  byte_t       byte_q[$];
  rec_t        exp_q[$];
  rec_t        instr_q[$];
  logic [59:0] rom [512];
  logic [15:0] pc_m;
  bit          halt_en = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  assign control_signals = rom[{cb_prefix, opcode}];

  task automatic check(string name, int unsigned act, int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: lays out the byte stream of one instruction and its expected result.
  task automatic push_instr(bit cb, logic [7:0] op, logic [15:0] iv, bit jmp, logic [15:0] tgt);
    rec_t        r;
    logic [8:0]  key;
    int unsigned ib, n;
    key = {cb, op};
    ib  = rom[key][1:0];
    if (cb) ib = 0;
    if (ib == 3) ib = 2;
    n = rom[key][5:2];
    if (n == 0) n = 1;
    if (cb) begin
      byte_q.push_back(byte_t'({8'hCB, pc_m}));
      pc_m = pc_m + 16'd1;
    end
    byte_q.push_back(byte_t'({op, pc_m}));
    pc_m = pc_m + 16'd1;
    if (ib >= 1) begin
      byte_q.push_back(byte_t'({iv[7:0], pc_m}));
      pc_m = pc_m + 16'd1;
    end
    if (ib >= 2) begin
      byte_q.push_back(byte_t'({iv[15:8], pc_m}));
      pc_m = pc_m + 16'd1;
    end
    r.op      = op;
    r.cb      = cb;
    r.imm     = (ib == 0) ? 16'h0000 : (ib == 1) ? {8'h00, iv[7:0]} : iv;
    r.pc_done = pc_m;
    r.n       = 5'(n);
    r.jmp     = jmp;
    r.tgt     = tgt;
    exp_q.push_back(r);
    instr_q.push_back(r);
    if (jmp) pc_m = tgt;
  endtask

  task automatic push_rand();
    bit         cb;
    logic [7:0] op;
    cb = ($urandom % 5) == 0;
    op = 8'($urandom);
    if (!cb && op == 8'hCB) op = 8'h00;
    push_instr(cb, op, 16'($urandom), ($urandom % 4) == 0, 16'($urandom));
  endtask

  task automatic wait_drain(string name);
    int t = 0;
    while ((exp_q.size() > 0 || byte_q.size() > 0) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check(name, exp_q.size() + byte_q.size(), 0);
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_mem_rd"}, mem_rd, 0);
    check({tag, "_pc"}, pc, RPC);
    check({tag, "_mem_addr"}, mem_addr, RPC);
    check({tag, "_opcode"}, opcode, 0);
    check({tag, "_cb"}, cb_prefix, 0);
    check({tag, "_imm"}, imm, 0);
    check({tag, "_step"}, exec_step, 0);
    check({tag, "_done"}, instr_done, 0);
    check({tag, "_active"}, exec_active, 0);
  endtask

  // Memory / jump driver: inputs change on the falling edge.
  int   ex_cnt = 0;
  rec_t drv_r;
  always @(negedge clk) begin
    if (!reset_n) begin
      ex_cnt  = 0;
      pc_load = 1'b0;
    end else if (exec_active && instr_q.size() > 0) begin
      drv_r = instr_q[0];
      if (ex_cnt == int'(drv_r.n) - 1) begin
        pc_load       = drv_r.jmp;
        pc_load_value = drv_r.tgt;
        void'(instr_q.pop_front());
        ex_cnt = 0;
      end else begin
        pc_load       = 1'($urandom);
        pc_load_value = 16'($urandom);
        ex_cnt++;
      end
    end else begin
      pc_load       = 1'($urandom);
      pc_load_value = 16'($urandom);
    end
    halt = halt_en && (($urandom % 4) == 0);
    if (byte_q.size() > 0) begin
      mem_rdata = byte_q[0].data;
      mem_ready = ($urandom % 3) != 0;
    end else begin
      mem_rdata = 8'($urandom);
      mem_ready = 1'b0;
    end
    #2;
    if (reset_n && mem_rd && byte_q.size() > 0) begin
      check("fetch_addr", mem_addr, byte_q[0].addr);
      if (mem_ready) void'(byte_q.pop_front());
    end
  end

  // Monitor: pops the scoreboard whenever the DUT signals instr_done.
  int   ex_len = 0;
  bit   prev_done = 1'b0;
  rec_t mon_r;
  always @(negedge clk) begin
    #1;
    if (!reset_n) begin
      ex_len    = 0;
      prev_done = 1'b0;
    end else begin
      check("mem_addr_eq_pc", mem_addr, pc);
      if (prev_done && !halt) check("no_gap_fetch", mem_rd, 1);
      prev_done = instr_done;
      if (exec_active) begin
        check("exec_step", exec_step, ex_len);
        ex_len++;
        if (instr_done) begin
          if (exp_q.size() == 0) begin
            check("done_without_expected", exp_q.size(), 1);
          end else begin
            mon_r = exp_q.pop_front();
            check("opcode", opcode, mon_r.op);
            check("cb_prefix", cb_prefix, mon_r.cb);
            check("imm", imm, mon_r.imm);
            check("pc_at_done", pc, mon_r.pc_done);
            check("exec_len", ex_len, mon_r.n);
          end
          ex_len = 0;
        end
      end else begin
        check("step_idle", exec_step, 0);
        check("done_idle", instr_done, 0);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = {28'($urandom), 32'($urandom)};
    rom[9'h000][5:0] = {4'd1, 2'd0};
    rom[9'h001][5:0] = {4'd3, 2'd2};
    rom[9'h137][5:0] = {4'd2, 2'd2};
    reset_n = 1'b0; halt = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    pc_load = 1'b0; pc_load_value = '0;
    repeat (3) @(negedge clk);
    #2;
    check_reset_vals("por");

    pc_m = RPC;
    push_instr(1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000);
    push_instr(1'b0, 8'h01, 16'h1234, 1'b0, 16'h0000);
    push_instr(1'b1, 8'h37, 16'hBEEF, 1'b1, 16'h0150);

    @(negedge clk);
    #3 reset_n = 1'b1;
    #1 check("mem_rd_before_first_edge", mem_rd, 0);
    @(negedge clk);
    #2 check("mem_rd_after_first_edge", mem_rd, 1);
    halt_en = 1'b1;
    repeat (120) push_rand();
    wait_drain("drain_phase1");

    // Abandon an instruction while it waits in IMM_HI.
    byte_q.push_back(byte_t'({8'h01, pc_m}));
    byte_q.push_back(byte_t'({8'h34, pc_m + 16'd1}));
    begin
      int t = 0;
      while (byte_q.size() > 0 && t < 2000) begin
        @(negedge clk);
        t++;
      end
      check("imm_hi_reach_timeout", byte_q.size(), 0);
    end
    @(negedge clk);
    #3;
    check("pre_reset_imm_lo", imm, 16'h0034);
    check("pre_reset_mem_rd", mem_rd, 1);
    check("pre_reset_addr", mem_addr, pc_m + 16'd2);
    reset_n = 1'b0;
    #1 check_reset_vals("async");
    byte_q.delete();
    exp_q.delete();
    instr_q.delete();
    pc_m = RPC;
    repeat (2) begin
      @(negedge clk);
      #1 check("done_in_reset", instr_done, 0);
      check("rd_in_reset", mem_rd, 0);
    end
    repeat (100) push_rand();
    #2 reset_n = 1'b1;
    wait_drain("drain_phase2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
